motor_pwm_driver: RTL and testbench

//   Consumer end of the PID correction interface. Once per PWM period it samples the

---
 rtl/motor_pwm_driver.sv | 204 ++++++++++++++++++++
 tb/tb_motor_pwm_driver.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : motor_pwm_driver                                                |
// | Brief    : Mixes a signed PID correction with a base speed into left/right |
// |            motor duties. Each duty is clamped, slew-limited and passes     |
// |            through a dead-time interval before a direction reversal.       |
// |            Drives the H-bridge PWM and direction pins.                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module motor_pwm_driver #(
    parameter int PWM_BITS     = 10,
    parameter int BASE_SPEED   = 600,
    parameter int SLEW_STEP    = 64,
    parameter int DEAD_PERIODS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic signed [12:0] pid_output,
    output logic               left_pwm,
    output logic               left_dir,
    output logic               right_pwm,
    output logic               right_dir,
    output logic               period_tick,
    output logic               saturated
);

    localparam int c_DW = (DEAD_PERIODS < 2) ? 1 : $clog2(DEAD_PERIODS + 1);

    localparam logic [PWM_BITS-1:0]  c_CNT_MAX   = '1;
    localparam logic [PWM_BITS-1:0]  c_CNT_ONE   = PWM_BITS'(1);
    localparam logic [PWM_BITS:0]    c_STEP      = (PWM_BITS + 1)'(SLEW_STEP);
    localparam logic signed [14:0]   c_BASE      = 15'(BASE_SPEED);
    localparam logic signed [14:0]   c_LIM       = 15'((1 << PWM_BITS) - 1);
    localparam logic [c_DW-1:0]      c_DEAD_INIT = c_DW'(DEAD_PERIODS);
    localparam logic [c_DW-1:0]      c_DEAD_ONE  = c_DW'(1);

    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_DEAD = 1'b1;

    // Move cur toward goal by at most one slew step, landing exactly on goal.
    function automatic logic [PWM_BITS-1:0] f_toward(input logic [PWM_BITS-1:0] cur,
                                                     input logic [PWM_BITS-1:0] goal);
        logic [PWM_BITS:0] diff;
        if (cur < goal) begin
            diff = {1'b0, goal} - {1'b0, cur};
            return (diff > c_STEP) ? PWM_BITS'({1'b0, cur} + c_STEP) : goal;
        end else begin
            diff = {1'b0, cur} - {1'b0, goal};
            return (diff > c_STEP) ? PWM_BITS'({1'b0, cur} - c_STEP) : goal;
        end
    endfunction

    logic [PWM_BITS-1:0] r_cnt;
    logic [PWM_BITS-1:0] w_cnt_next;
    logic                w_wrap;
    logic                r_tick;
    logic                r_sat;

    assign w_wrap     = (r_cnt == c_CNT_MAX);
    assign w_cnt_next = r_cnt + c_CNT_ONE;

    // Free-running period counter; the tick marks cnt==0 after each wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= w_wrap;
        end
    end

    // Differential mix; 15 bits holds BASE +/- the full 13-bit correction.
    logic signed [14:0] w_pid_ext;
    logic signed [14:0] w_mix [2];

    assign w_pid_ext = {{2{pid_output[12]}}, pid_output};
    assign w_mix[0]  = enable ? (c_BASE + w_pid_ext) : '0;
    assign w_mix[1]  = enable ? (c_BASE - w_pid_ext) : '0;

    logic [1:0] w_clip_all;
    logic [1:0] w_pwm_all;
    logic [1:0] w_dir_all;

    // Index 0 is the left motor, index 1 the right motor.
    for (genvar i = 0; i < 2; i++) begin : g_motor
        logic [0:0]          r_state, w_state_next;
        logic [PWM_BITS-1:0] r_mag, w_mag_next;
        logic                r_dir, w_dir_next;
        logic [c_DW-1:0]     r_dead, w_dead_next;
        logic                r_pwm, w_pwm_d;
        logic signed [14:0]  w_tgt;
        logic                w_clip;
        logic                w_neg;
        logic                w_pos;
        logic                w_opp;
        logic                w_opp_after_flip;
        logic [PWM_BITS-1:0] w_abs;

        // Clamp the mixed target symmetrically to the largest duty.
        always_comb begin
            w_tgt  = w_mix[i];
            w_clip = 1'b0;
            if (w_mix[i] > c_LIM) begin
                w_tgt  = c_LIM;
                w_clip = 1'b1;
            end else if (w_mix[i] < -c_LIM) begin
                w_tgt  = -c_LIM;
                w_clip = 1'b1;
            end
        end

        assign w_neg = w_tgt[14];
        assign w_pos = !w_tgt[14] && (w_tgt != '0);
        assign w_abs = PWM_BITS'(w_neg ? -w_tgt : w_tgt);
        // A zero target never opposes the current direction.
        assign w_opp            = (w_neg && r_dir) || (w_pos && !r_dir);
        assign w_opp_after_flip = (w_neg && !r_dir) || (w_pos && r_dir);

        // State register: FSM, duty magnitude, direction, dead counter, PWM flop.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= c_ST_RUN;
                r_mag   <= '0;
                r_dir   <= 1'b1;
                r_dead  <= '0;
                r_pwm   <= 1'b0;
            end else begin
                r_state <= w_state_next;
                r_mag   <= w_mag_next;
                r_dir   <= w_dir_next;
                r_dead  <= w_dead_next;
                r_pwm   <= w_pwm_d;
            end
        end

        // Next-state logic, evaluated only at the sample edge.
        always_comb begin
            w_state_next = r_state;
            w_mag_next   = r_mag;
            w_dir_next   = r_dir;
            w_dead_next  = r_dead;
            if (w_wrap) begin
                case (r_state)
                    c_ST_RUN: begin
                        if (!w_opp) begin
                            w_mag_next = f_toward(r_mag, w_abs);
                        end else if (r_mag != '0) begin
                            w_mag_next = f_toward(r_mag, '0);
                        end else if (DEAD_PERIODS > 0) begin
                            w_state_next = c_ST_DEAD;
                            w_dead_next  = c_DEAD_INIT;
                        end else begin
                            w_dir_next = ~r_dir;
                            w_mag_next = f_toward('0, w_abs);
                        end
                    end
                    c_ST_DEAD: begin
                        w_dead_next = r_dead - c_DEAD_ONE;
                        if (r_dead == c_DEAD_ONE) begin
                            // The flip always completes; if the sign has swung back
                            // the motor simply restarts from zero duty.
                            w_state_next = c_ST_RUN;
                            w_dir_next   = ~r_dir;
                            w_mag_next   = w_opp_after_flip ? '0 : f_toward('0, w_abs);
                        end
                    end
                    default: begin
                        w_state_next = c_ST_RUN;
                        w_mag_next   = '0;
                    end
                endcase
            end
        end

        // Output logic: PWM high while the upcoming count is below the upcoming duty.
        always_comb begin
            w_pwm_d = (w_cnt_next < w_mag_next);
        end

        assign w_clip_all[i] = w_clip;
        assign w_pwm_all[i]  = r_pwm;
        assign w_dir_all[i]  = r_dir;
    end

    // Saturation flag reflects the most recent sample only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (w_wrap) begin
            r_sat <= |w_clip_all;
        end
    end

    assign left_pwm    = w_pwm_all[0];
    assign right_pwm   = w_pwm_all[1];
    assign left_dir    = w_dir_all[0];
    assign right_dir   = w_dir_all[1];
    assign period_tick = r_tick;
    assign saturated   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_motor_pwm_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_motor_pwm_driver                                             |
// | Brief    : Directed self-checking bench for motor_pwm_driver (defaults).    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_motor_pwm_driver;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic signed [12:0] pid_output = '0;
    logic               left_pwm;
    logic               left_dir;
    logic               right_pwm;
    logic               right_dir;
    logic               period_tick;
    logic               saturated;

    int checks   = 0;
    int failures = 0;

    motor_pwm_driver #(
        .PWM_BITS    (10),
        .BASE_SPEED  (600),
        .SLEW_STEP   (64),
        .DEAD_PERIODS(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pid_output (pid_output),
        .left_pwm   (left_pwm),
        .left_dir   (left_dir),
        .right_pwm  (right_pwm),
        .right_dir  (right_dir),
        .period_tick(period_tick),
        .saturated  (saturated)
    );

    always #5 clk = ~clk;

    // Waits (bounded) for a tick, then counts high cycles over one full period.
    // Returns at the negedge of the last cycle, just before the next sample edge.
    task automatic measure(output int l_hi, output int r_hi,
                           output logic l_d, output logic r_d, output int ticks);
        int guard = 0;
        l_hi = 0; r_hi = 0; ticks = 0; l_d = 1'bx; r_d = 1'bx;
        while (!period_tick && guard < 2100) begin
            @(negedge clk);
            guard++;
        end
        if (!period_tick) begin
            checks++; failures++;
            $display("FAIL period_wait: got no tick within %0d cycles, required one", guard);
            l_hi = -1; r_hi = -1;
            return;
        end
        l_d = left_dir;
        r_d = right_dir;
        for (int c = 0; c < 1024; c++) begin
            if (c != 0) @(negedge clk);
            l_hi  += int'(left_pwm);
            r_hi  += int'(right_pwm);
            ticks += int'(period_tick);
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; enable = 1'b1; pid_output = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({left_pwm, left_dir, right_pwm, right_dir, period_tick, saturated} !== 6'b010100) begin
            failures++;
            $display("FAIL reset_state: got %b required 010100",
                     {left_pwm, left_dir, right_pwm, right_dir, period_tick, saturated});
        end
        rst = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!period_tick && n < 2000);
        checks++;
        if (n != 1024) begin
            failures++;
            $display("FAIL first_tick: got %0d cycles required 1024", n);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({left_pwm, right_pwm} !== 2'b11) begin
            failures++;
            $display("FAIL pwm_high_before_reset: got %b required 11", {left_pwm, right_pwm});
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({left_pwm, left_dir, right_pwm, right_dir, period_tick, saturated} !== 6'b010100) begin
            failures++;
            $display("FAIL async_reset: got %b required 010100",
                     {left_pwm, left_dir, right_pwm, right_dir, period_tick, saturated});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!period_tick && n < 2000);
        checks++;
        if (n != 1024) begin
            failures++;
            $display("FAIL tick_after_reset: got %0d cycles required 1024", n);
        end
    endtask

    task automatic test_ramp();
        int   exp_m[10] = '{64, 128, 192, 256, 320, 384, 448, 512, 576, 600};
        int   l, r, t;
        logic ld, rd;
        for (int k = 0; k < 10; k++) begin
            measure(l, r, ld, rd, t);
            checks++;
            if (l != exp_m[k] || r != exp_m[k]) begin
                failures++;
                $display("FAIL ramp p%0d: got L=%0d R=%0d required %0d", k, l, r, exp_m[k]);
            end
            checks++;
            if ({ld, rd} !== 2'b11) begin
                failures++;
                $display("FAIL ramp_dir p%0d: got %b required 11", k, {ld, rd});
            end
            if (k == 0) begin
                checks++;
                if (t != 1) begin
                    failures++;
                    $display("FAIL tick_width: got %0d ticks per period required 1", t);
                end
            end
        end
        checks++;
        if (saturated !== 1'b0) begin
            failures++;
            $display("FAIL ramp_sat: got %b required 0", saturated);
        end
    endtask

    task automatic test_steer();
        int   exp_l[4] = '{664, 728, 792, 800};
        int   exp_r[4] = '{536, 472, 408, 400};
        int   l, r, t;
        logic ld, rd;
        pid_output = 13'sd200;
        for (int k = 0; k < 4; k++) begin
            measure(l, r, ld, rd, t);
            checks++;
            if (l != exp_l[k] || r != exp_r[k]) begin
                failures++;
                $display("FAIL steer p%0d: got L=%0d R=%0d required L=%0d R=%0d",
                         k, l, r, exp_l[k], exp_r[k]);
            end
        end
        checks++;
        if (saturated !== 1'b0) begin
            failures++;
            $display("FAIL steer_sat: got %b required 0", saturated);
        end
    endtask

    task automatic test_midperiod();
        int   exp_l[3] = '{736, 672, 608};
        int   exp_r[3] = '{336, 272, 208};
        int   l, r, t, guard;
        logic ld, rd;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!period_tick && guard < 2100);
        l = 0; r = 0;
        for (int c = 0; c < 1024; c++) begin
            if (c != 0) @(negedge clk);
            if (c == 300) pid_output = 13'sd1000;
            if (c == 600) enable = 1'b0;
            if (c == 900) pid_output = -13'sd700;
            l += int'(left_pwm);
            r += int'(right_pwm);
        end
        checks++;
        if (l != 800 || r != 400) begin
            failures++;
            $display("FAIL midperiod_hold: got L=%0d R=%0d required L=800 R=400", l, r);
        end
        for (int k = 0; k < 3; k++) begin
            measure(l, r, ld, rd, t);
            checks++;
            if (l != exp_l[k] || r != exp_r[k] || {ld, rd} !== 2'b11) begin
                failures++;
                $display("FAIL disable_decay p%0d: got L=%0d R=%0d dir=%b required L=%0d R=%0d dir=11",
                         k, l, r, {ld, rd}, exp_l[k], exp_r[k]);
            end
        end
        checks++;
        if (saturated !== 1'b0) begin
            failures++;
            $display("FAIL disable_sat: got %b required 0", saturated);
        end
    endtask

    task automatic test_recover();
        int   exp_r[7] = '{272, 336, 400, 464, 528, 592, 600};
        int   l, r, t;
        logic ld, rd;
        enable = 1'b1;
        pid_output = '0;
        for (int k = 0; k < 7; k++) begin
            measure(l, r, ld, rd, t);
            checks++;
            if (l != 600 || r != exp_r[k]) begin
                failures++;
                $display("FAIL recover p%0d: got L=%0d R=%0d required L=600 R=%0d",
                         k, l, r, exp_r[k]);
            end
        end
    endtask

    task automatic test_saturate();
        int   exp_l[16] = '{664, 728, 792, 856, 920, 984, 1023, 1023,
                            1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023};
        int   exp_r[16] = '{536, 472, 408, 344, 280, 216, 152, 88,
                            24, 0, 0, 0, 64, 128, 192, 200};
        logic exp_rd[16] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        int   l, r, t;
        logic ld, rd;
        pid_output = 13'sd800;
        for (int k = 0; k < 16; k++) begin
            measure(l, r, ld, rd, t);
            checks++;
            if (l != exp_l[k] || r != exp_r[k]) begin
                failures++;
                $display("FAIL saturate p%0d: got L=%0d R=%0d required L=%0d R=%0d",
                         k, l, r, exp_l[k], exp_r[k]);
            end
            checks++;
            if (ld !== 1'b1 || rd !== exp_rd[k]) begin
                failures++;
                $display("FAIL saturate_dir p%0d: got L=%b R=%b required L=1 R=%b",
                         k, ld, rd, exp_rd[k]);
            end
        end
        checks++;
        if (saturated !== 1'b1) begin
            failures++;
            $display("FAIL saturate_flag: got %b required 1", saturated);
        end
    endtask

    task automatic test_full_reverse();
        int   exp_l[20] = '{959, 895, 831, 767, 703, 639, 575, 511, 447, 383,
                            319, 255, 191, 127, 63, 0, 0, 0, 64, 128};
        int   exp_r[20] = '{136, 72, 8, 0, 0, 0, 64, 128, 192, 256,
                            320, 384, 448, 512, 576, 640, 704, 768, 832, 896};
        int   l, r, t;
        logic ld, rd;
        logic exp_ld, exp_rd;
        logic [12:0] raw = 13'h1000;
        pid_output = raw;
        for (int k = 0; k < 20; k++) begin
            measure(l, r, ld, rd, t);
            exp_ld = (k < 18);
            exp_rd = (k >= 6);
            checks++;
            if (l != exp_l[k] || r != exp_r[k]) begin
                failures++;
                $display("FAIL reverse p%0d: got L=%0d R=%0d required L=%0d R=%0d",
                         k, l, r, exp_l[k], exp_r[k]);
            end
            checks++;
            if (ld !== exp_ld || rd !== exp_rd) begin
                failures++;
                $display("FAIL reverse_dir p%0d: got L=%b R=%b required L=%b R=%b",
                         k, ld, rd, exp_ld, exp_rd);
            end
        end
        checks++;
        if (saturated !== 1'b1) begin
            failures++;
            $display("FAIL reverse_sat: got %b required 1", saturated);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_steer();
        test_midperiod();
        test_recover();
        test_saturate();
        test_full_reverse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
